// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared pipeline types for the instruction fetch stage
package fetch_unit_pkg;

    localparam logic [63:0] PC_RESET_DEFAULT = 64'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [63:0] pc;
    } fetch_instr_t;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with one-entry skid and redirect discard
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        busy
);

    fetch_state_t state, nstate;
    logic [63:0]  pc, npc, req_addr;
    logic         load_req, take;
    fetch_instr_t out_r, skid;

    // State register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= nstate;

    // Next state: a response always ends the transaction; a redirect without one must wait it out in DISCARD
    always_comb begin
        nstate = state == IDLE ? ((!stall && (redirect || !skid.valid)) ? REQ : IDLE)
               : iresp_data_ok ? (stall ? IDLE : REQ)
               : (state == REQ && redirect) ? DISCARD : state;
    end

    // Next pc, request-address load and word-acceptance decode
    always_comb begin
        npc      = redirect ? redirect_pc : (state == REQ && iresp_data_ok) ? req_addr + 64'd4 : pc;
        load_req = nstate == REQ && (state != REQ || iresp_data_ok);
        take     = state == REQ && iresp_data_ok && !redirect;
    end

    // Outputs: the bus sees only the latched request address, never the live pc
    always_comb begin
        ireq_valid = state != IDLE;
        ireq_addr  = req_addr;
        busy       = (state == REQ && !iresp_data_ok) || state == DISCARD;
        out_valid  = out_r.valid;
        out_instr  = out_r.instr;
        out_pc     = out_r.pc;
    end

    // Datapath: pc, request address, decode-facing output register and skid entry
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pc       <= PC_RESET;
            req_addr <= PC_RESET;
            out_r    <= '0;
            skid     <= '0;
        end else begin
            pc <= npc;
            if (load_req) req_addr <= npc;
            if (redirect) begin
                out_r.valid <= 1'b0;
                skid.valid  <= 1'b0;
            end else if (!stall) begin
                if (skid.valid) begin
                    out_r      <= skid;
                    skid.valid <= 1'b0;
                end else if (take) out_r <= '{1'b1, iresp_data, req_addr};
                else out_r.valid <= 1'b0;
            end else if (take) begin
                assert (!skid.valid);
                skid <= '{1'b1, iresp_data, req_addr};
            end
        end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_RESET, default 64'h8000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  downstream not accepting (load-use or CSR stall); SHALL NOT depend combinationally on busy.
REQ-005 redirect  input  1  taken jump/branch or CSR flush; discard all fetched and in-flight work.
REQ-006 redirect_pc  input  64  new fetch address, valid when redirect=1.
REQ-007 ireq_valid  output  1  instruction-bus request valid.
REQ-008 ireq_addr  output  64  request address, stable while ireq_valid=1.
REQ-009 iresp_data_ok  input  1  response for the outstanding request, one cycle.
REQ-010 iresp_data  input  32  instruction word, valid with iresp_data_ok.
REQ-011 out_valid / out_instr / out_pc  output  1/32/64  registered instruction to decode.
REQ-012 busy  output  1  fetch waiting on memory; feeds the control unit's invalid input.

Function
REQ-013 States SHALL be IDLE (no request), REQ (request outstanding), DISCARD (outstanding request whose response is dropped).
REQ-014 ireq_valid SHALL be 1 in REQ and DISCARD, 0 in IDLE; ireq_addr SHALL come from a req_addr register loaded on entry to REQ, never from pc directly.
REQ-015 Once asserted, ireq_valid and ireq_addr SHALL hold until the cycle iresp_data_ok=1; no request is abandoned.
REQ-016 busy SHALL equal (state==REQ && !iresp_data_ok) || state==DISCARD.
REQ-017 Event priority per cycle: reset > redirect > stall > response.
REQ-018 IDLE: redirect loads pc<=redirect_pc; when stall=0 and skid empty -> REQ with req_addr<=effective pc.
REQ-019 REQ, data_ok, no redirect: if stall=0 load out regs {1, iresp_data, req_addr}; else load skid register; pc<=req_addr+4 (64-bit wrap); next REQ if stall=0, else IDLE.
REQ-020 REQ, redirect without data_ok -> DISCARD, pc<=redirect_pc; REQ, redirect with data_ok -> data dropped, pc<=redirect_pc, next REQ if stall=0 else IDLE.
REQ-021 DISCARD: on data_ok drop data -> REQ (stall=0) or IDLE; redirect in DISCARD overwrites pc again, stays DISCARD.
REQ-022 Redirect SHALL clear out_valid and skid_valid the same edge.
REQ-023 stall=1 SHALL hold out regs unchanged; stall=0 with no new word and skid empty SHALL clear out_valid (bubble).
REQ-024 stall=0 with skid_valid=1 SHALL move skid to out regs and clear skid before any new request issues.
REQ-025 Steady state, stall=0, data_ok one cycle after request: one instruction per cycle, out appears one edge after data_ok.
REQ-026 Skid depth one; skid full with new response impossible by REQ-018 and SHALL be asserted in simulation.

Reset
REQ-027 Reset: pc=PC_RESET, state=IDLE, out_valid=0, out_instr=0, out_pc=0, skid_valid=0, ireq_valid=0, busy=0.
REQ-028 First request (addr PC_RESET) SHALL issue the first cycle after reset deassertion with stall=0.
REQ-029 Reset mid-request abandons it; the bus slave is reset by the same signal.

Structure
REQ-030 Fetch state enum, PC_RESET default and the fetched-instruction struct {valid, instr, pc} SHALL live in the shared pipes package.
REQ-031 No sub-modules; the skid buffer is inline registers.

Verification
REQ-032 Reset, stall=0, memory returns data_ok next cycle -> ireq_addr 0x8000_0000, 0x8000_0004, 0x8000_0008; out_pc follows one edge later.
REQ-033 data_ok delayed 3 cycles -> busy=1 for 3 cycles, ireq_addr stable, then out_instr equals returned word.
REQ-034 redirect to 0x8000_0100 while request outstanding -> DISCARD; stale word never reaches out_valid; next ireq_addr 0x8000_0100.
REQ-035 stall rises mid-request, data_ok arrives -> word held in skid, out unchanged; stall drops -> skid word on out next edge, then fetch resumes at +4.
REQ-036 redirect and data_ok same cycle -> word dropped, out_valid=0, next request at redirect_pc.
REQ-037 Reset asserted during DISCARD -> all outputs per REQ-027 immediately, asynchronously.
